itrx_aib_phy_io_dir_seq: RTL and testbench
==========================================

// Module: itrx_aib_phy_io_dir_seq
// PURPOSE
// - Per-IO direction/enable sequencer; sits directly upstream of the analog AIB IO buffer and drives all its digital controls.
// - Converts static mode config into glitch-free, ordered enable sequences: drive strength before TX enable; TX release plus turnaround before RX.
// - Registers TX data into txdat_mux. Holds the pad in a safe state (TX off, RX off, weak pulldown) during POR.
// PARAMETERS
// - SETUP_CYC  2  cycles drive strength is applied before tx_en_buf asserts (1..2^CNT_W-1)
// - TURN_CYC   4  cycles between tx_en_buf deassert and rx enable (1..2^CNT_W-1)
// - CNT_W      4  width of the shared sequencing counter
// PORTS
// - clk          in   1  IO-channel clock
// - rst_n        in   1  asynchronous active-low reset
// - por_vcc_io   in   1  IO-domain POR, async, active-high
// - por_vcc_dig  in   1  core-domain POR, async, active-high
// - cfg_tx_en    in   1  request TX mode (priority over cfg_rx_en)
// - cfg_rx_en    in   1  request RX mode
// - cfg_rx_clk   in   1  1: RX path is clock (rx_clk_en), 0: data (rx_dat_en)
// - cfg_wkpu     in   1  weak pull-up request when not transmitting
// - cfg_wkpd     in   1  weak pull-down request when not transmitting
// - cfg_drv      in   2  drive strength, copied to ipdrv/indrv
// - tx_data      in   1  TX data bit, sampled every clk
// - txdat_mux    out  1  registered TX data to IO buffer
// - tx_en_buf    out  1  TX driver enable
// - ipdrv        out  2  PMOS drive strength
// - indrv        out  2  NMOS drive strength
// - weakp1       out  1  weak pull-up enable
// - weakp0       out  1  weak pull-down enable
// - rx_dat_en    out  1  RX data receiver enable
// - rx_clk_en    out  1  RX clock receiver enable
// - seq_busy     out  1  1 in TX_SETUP or TURN
// - cfg_err      out  1  sticky: cfg_wkpu & cfg_wkpd seen; cleared by reset/POR
// BEHAVIOUR
// - Reset (rst_n=0) or synced POR=1: state OFF, counter 0, all outputs 0 except weakp0=1; ipdrv/indrv=0.
// - POR sync: por_any = por_vcc_io|por_vcc_dig; 2-flop sync with async assert, sync deassert (2-cycle release).
// - POR assert mid-operation: same cycle forces OFF and the safe output state, overriding any state.
// - Mode request: TX if cfg_tx_en; else RX if cfg_rx_en; else OFF.
// - States: OFF, TX_SETUP, TX, TURN, RX.
//   OFF -> TX_SETUP on TX req (load SETUP_CYC-1); OFF -> RX on RX req (pad was never driven).
//   TX_SETUP: ipdrv/indrv=cfg_drv, tx off; count down; at 0 -> TX. Request drops -> OFF immediately.
//   TX: tx_en_buf=1; exit when TX req drops -> TURN (load TURN_CYC-1).
//   TURN: tx_en_buf=0, rx off; count to 0 -> RX if RX req, OFF if none, TX_SETUP if TX req reappears.
//   RX: rx_dat_en=~cfg_rx_clk, rx_clk_en=cfg_rx_clk; TX req -> TX_SETUP (rx enables drop same edge); no req -> OFF.
// - All control outputs registered from next-state; state change and output change on the same edge; no output glitches.
// - tx_en_buf never 1 while rx_dat_en|rx_clk_en is 1; never 1 with ipdrv=indrv=0 unless cfg_drv=0.
// - ipdrv/indrv: cfg_drv in TX_SETUP/TX, held during TURN, 0 in OFF/RX.
// - txdat_mux: registered tx_data when next state is TX, else 0; latency 1 clk.
// - Weak pulls (OFF, TURN, RX only): weakp1=cfg_wkpu&~cfg_wkpd; weakp0=cfg_wkpd&~cfg_wkpu; both set -> both 0, cfg_err=1. Both 0 in TX_SETUP/TX.
// - cfg_rx_clk change while in RX: enables swap on the next edge; no TURN needed.
// STRUCTURE
// - Shared package: state enum encoding (OFF=0,TX_SETUP=1,TX=2,TURN=3,RX=4), default SETUP_CYC/TURN_CYC constants.
// - One sub-module: itrx_aib_phy_por_sync (2-flop async-assert POR synchronizer), reusable across IO cells.
// - FSM, counter and output registers live in this module.
// TESTING
// - Reset release, por_vcc_io=1 -> all outputs 0, weakp0=1; drop POR -> outputs unchanged for 2 clk, then state OFF.
// - cfg_tx_en=1, cfg_drv=2'b10 -> ipdrv=indrv=2'b10 next edge; tx_en_buf=1 exactly SETUP_CYC clk later; txdat_mux follows tx_data 1 clk late.
// - TX -> RX (cfg_tx_en 1->0, cfg_rx_en=1) -> tx_en_buf=0 next edge; rx_dat_en=1 exactly TURN_CYC clk later; no overlap.
// - RX with cfg_rx_clk=1 -> rx_clk_en=1, rx_dat_en=0; toggle cfg_rx_clk -> enables swap next edge.
// - por_vcc_dig pulse while in TX -> tx_en_buf=0, weakp0=1 asynchronously; resumes via TX_SETUP after release.
// - cfg_wkpu=cfg_wkpd=1 in OFF -> weakp0=weakp1=0, cfg_err=1 and stays 1 after config fixed.

Source files
------------

// File: rtl/itrx_aib_phy_io_dir_seq_pkg.sv
// Shared types and defaults for the AIB IO direction sequencer.
package itrx_aib_phy_io_dir_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_TX_SETUP = 3'd1,
    ST_TX       = 3'd2,
    ST_TURN     = 3'd3,
    ST_RX       = 3'd4
  } seq_state_e;

  localparam int SETUP_CYC_DEF = 2;
  localparam int TURN_CYC_DEF  = 4;
  localparam int CNT_W_DEF     = 4;

  typedef struct packed {
    logic       txdat;
    logic       tx_en;
    logic [1:0] ipdrv;
    logic [1:0] indrv;
    logic       weakp1;
    logic       weakp0;
    logic       rx_dat_en;
    logic       rx_clk_en;
    logic       busy;
  } pad_ctl_t;

  // Pad parked: nothing driven or received, weak pulldown holds the line low.
  function automatic pad_ctl_t safe_ctl();
    pad_ctl_t c;
    c        = '0;
    c.weakp0 = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/itrx_aib_phy_por_sync.sv
// POR synchronizer: asserts asynchronously, releases after two clean clocks.
module itrx_aib_phy_por_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic por_in,
  output logic por_out
);

  logic [1:0] ff;

  // Reset parks the chain asserted so the pad stays safe for two clocks after rst_n release.
  always_ff @(posedge clk or negedge rst_n or posedge por_in) begin
    if (!rst_n)      ff <= 2'b11;
    else if (por_in) ff <= 2'b11;
    else             ff <= {ff[0], 1'b0};
  end

  assign por_out = ff[1];

endmodule

// File: rtl/itrx_aib_phy_io_dir_seq.sv
// Per-IO direction/enable sequencer driving the analog AIB IO buffer controls.
module itrx_aib_phy_io_dir_seq
  import itrx_aib_phy_io_dir_seq_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int TURN_CYC  = TURN_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       por_vcc_io,
  input  logic       por_vcc_dig,
  input  logic       cfg_tx_en,
  input  logic       cfg_rx_en,
  input  logic       cfg_rx_clk,
  input  logic       cfg_wkpu,
  input  logic       cfg_wkpd,
  input  logic [1:0] cfg_drv,
  input  logic       tx_data,
  output logic       txdat_mux,
  output logic       tx_en_buf,
  output logic [1:0] ipdrv,
  output logic [1:0] indrv,
  output logic       weakp1,
  output logic       weakp0,
  output logic       rx_dat_en,
  output logic       rx_clk_en,
  output logic       seq_busy,
  output logic       cfg_err
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC - 1);

  logic por_any, por_s, rst_int_n;

  assign por_any = por_vcc_io | por_vcc_dig;

  itrx_aib_phy_por_sync u_por_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .por_in (por_any),
    .por_out(por_s)
  );

  // POR rises the synchronizer asynchronously, so this also clears the FSM the same cycle.
  assign rst_int_n = rst_n & ~por_s;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pad_ctl_t         ctl_q, ctl_d;
  logic             err_q;
  logic             req_tx, req_rx, pulls_on;

  assign req_tx = cfg_tx_en;
  assign req_rx = ~cfg_tx_en & cfg_rx_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (req_tx) begin
          state_d = ST_TX_SETUP;
          cnt_d   = SETUP_LD;
        end else if (req_rx) begin
          state_d = ST_RX;
        end
      end
      ST_TX_SETUP: begin
        if (!req_tx)            state_d = ST_OFF;
        else if (cnt_q == '0)   state_d = ST_TX;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      ST_TX: begin
        if (!req_tx) begin
          state_d = ST_TURN;
          cnt_d   = TURN_LD;
        end
      end
      ST_TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (req_tx) begin
          state_d = ST_TX_SETUP;
          cnt_d   = SETUP_LD;
        end else if (req_rx) begin
          state_d = ST_RX;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_RX: begin
        if (req_tx) begin
          state_d = ST_TX_SETUP;
          cnt_d   = SETUP_LD;
        end else if (!req_rx) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs come from next state so every control flips on the same edge as the state.
  always_comb begin
    ctl_d    = '0;
    pulls_on = (state_d == ST_OFF) || (state_d == ST_TURN) || (state_d == ST_RX);
    ctl_d.tx_en     = (state_d == ST_TX);
    ctl_d.txdat     = (state_d == ST_TX) & tx_data;
    ctl_d.busy      = (state_d == ST_TX_SETUP) || (state_d == ST_TURN);
    ctl_d.rx_dat_en = (state_d == ST_RX) & ~cfg_rx_clk;
    ctl_d.rx_clk_en = (state_d == ST_RX) & cfg_rx_clk;
    ctl_d.weakp1    = pulls_on & cfg_wkpu & ~cfg_wkpd;
    ctl_d.weakp0    = pulls_on & cfg_wkpd & ~cfg_wkpu;
    if ((state_d == ST_TX_SETUP) || (state_d == ST_TX)) begin
      ctl_d.ipdrv = cfg_drv;
      ctl_d.indrv = cfg_drv;
    end else if (state_d == ST_TURN) begin
      ctl_d.ipdrv = ctl_q.ipdrv;
      ctl_d.indrv = ctl_q.indrv;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      ctl_q   <= safe_ctl();
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      err_q   <= err_q | (cfg_wkpu & cfg_wkpd);
    end
  end

  assign txdat_mux = ctl_q.txdat;
  assign tx_en_buf = ctl_q.tx_en;
  assign ipdrv     = ctl_q.ipdrv;
  assign indrv     = ctl_q.indrv;
  assign weakp1    = ctl_q.weakp1;
  assign weakp0    = ctl_q.weakp0;
  assign rx_dat_en = ctl_q.rx_dat_en;
  assign rx_clk_en = ctl_q.rx_clk_en;
  assign seq_busy  = ctl_q.busy;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_itrx_aib_phy_io_dir_seq.sv
// Scoreboard bench: a phase/elapsed-time model predicts each edge's pad controls.
module tb_itrx_aib_phy_io_dir_seq;

  localparam int SETUP = 2;
  localparam int TURN  = 4;
  localparam logic [11:0] SAFE = 12'h010;

  logic       clk = 1'b0;
  logic       rst_n, por_vcc_io, por_vcc_dig;
  logic       cfg_tx_en, cfg_rx_en, cfg_rx_clk, cfg_wkpu, cfg_wkpd;
  logic [1:0] cfg_drv;
  logic       tx_data;
  logic       txdat_mux, tx_en_buf, weakp1, weakp0, rx_dat_en, rx_clk_en, seq_busy, cfg_err;
  logic [1:0] ipdrv, indrv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itrx_aib_phy_io_dir_seq #(.SETUP_CYC(SETUP), .TURN_CYC(TURN), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .por_vcc_io(por_vcc_io), .por_vcc_dig(por_vcc_dig),
    .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en), .cfg_rx_clk(cfg_rx_clk),
    .cfg_wkpu(cfg_wkpu), .cfg_wkpd(cfg_wkpd), .cfg_drv(cfg_drv), .tx_data(tx_data),
    .txdat_mux(txdat_mux), .tx_en_buf(tx_en_buf), .ipdrv(ipdrv), .indrv(indrv),
    .weakp1(weakp1), .weakp0(weakp0), .rx_dat_en(rx_dat_en), .rx_clk_en(rx_clk_en),
    .seq_busy(seq_busy), .cfg_err(cfg_err)
  );

  // {txdat, tx_en, ipdrv, indrv, weakp1, weakp0, rx_dat, rx_clk, busy, err}
  function automatic logic [11:0] act_vec();
    return {txdat_mux, tx_en_buf, ipdrv, indrv, weakp1, weakp0, rx_dat_en, rx_clk_en, seq_busy, cfg_err};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_PREP, M_DRIVE, M_GAP, M_LISTEN} mph_t;
  mph_t       m_ph = M_IDLE;
  int         m_el = 0;
  int         m_rel = 2;
  logic       m_err = 1'b0;
  logic [1:0] m_drv = 2'b00;
  logic [11:0] exp_q[$];

  task automatic model_edge();
    logic [11:0] e;
    logic        listen, pulls;
    if (!rst_n || por_vcc_io || por_vcc_dig) begin
      m_rel = 2; m_ph = M_IDLE; m_err = 1'b0; m_drv = 2'b00; e = SAFE;
    end else if (m_rel > 0) begin
      m_rel--; m_ph = M_IDLE; m_err = 1'b0; m_drv = 2'b00; e = SAFE;
    end else begin
      m_err = m_err | (cfg_wkpu & cfg_wkpd);
      case (m_ph)
        M_IDLE:   if (cfg_tx_en) begin m_ph = M_PREP; m_el = 1; end
                  else if (cfg_rx_en) m_ph = M_LISTEN;
        M_PREP:   if (!cfg_tx_en) m_ph = M_IDLE;
                  else if (m_el >= SETUP) m_ph = M_DRIVE;
                  else m_el++;
        M_DRIVE:  if (!cfg_tx_en) begin m_ph = M_GAP; m_el = 1; end
        M_GAP:    if (m_el < TURN) m_el++;
                  else if (cfg_tx_en) begin m_ph = M_PREP; m_el = 1; end
                  else if (cfg_rx_en) m_ph = M_LISTEN;
                  else m_ph = M_IDLE;
        M_LISTEN: if (cfg_tx_en) begin m_ph = M_PREP; m_el = 1; end
                  else if (!cfg_rx_en) m_ph = M_IDLE;
        default:  m_ph = M_IDLE;
      endcase
      if (m_ph == M_PREP || m_ph == M_DRIVE) m_drv = cfg_drv;
      else if (m_ph != M_GAP)               m_drv = 2'b00;
      listen = (m_ph == M_LISTEN);
      pulls  = (m_ph == M_IDLE) || (m_ph == M_GAP) || listen;
      e = {(m_ph == M_DRIVE) & tx_data, m_ph == M_DRIVE, m_drv, m_drv,
           pulls & cfg_wkpu & ~cfg_wkpd, pulls & cfg_wkpd & ~cfg_wkpu,
           listen & ~cfg_rx_clk, listen & cfg_rx_clk,
           (m_ph == M_PREP) || (m_ph == M_GAP), m_err};
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [11:0] e, a;
    #1;
    a = act_vec();
    checks++;
    if (a[10] && (a[3] || a[2])) begin
      errors++;
      $display("FAIL tx_rx_overlap t=%0t outputs=%h (tx_en with rx enable)", $time, a);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pad_ctl t=%0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      tx_data = 1'($urandom);
      model_edge();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_async(input string nm);
    #1;
    checks++;
    if (act_vec() !== SAFE) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act_vec(), SAFE);
    end
  endtask

  initial begin
    int por_left;
    rst_n = 1'b0; por_vcc_io = 1'b0; por_vcc_dig = 1'b0;
    cfg_tx_en = 1'b0; cfg_rx_en = 1'b0; cfg_rx_clk = 1'b0;
    cfg_wkpu = 1'b0; cfg_wkpd = 1'b0; cfg_drv = 2'b00; tx_data = 1'b0;
    @(negedge clk);
    check_async("reset_state");
    step(2);
    // reset release under IO POR, then POR release
    rst_n = 1'b1; por_vcc_io = 1'b1;
    step(3);
    por_vcc_io = 1'b0;
    step(4);
    // TX bring-up
    cfg_tx_en = 1'b1; cfg_drv = 2'b10;
    step(8);
    // TX -> RX turnaround
    cfg_tx_en = 1'b0; cfg_rx_en = 1'b1;
    step(8);
    // RX clock/data swap
    cfg_rx_clk = 1'b1; step(3);
    cfg_rx_clk = 1'b0; step(3);
    // POR pulse during TX
    cfg_tx_en = 1'b1; cfg_drv = 2'b01; step(6);
    por_vcc_dig = 1'b1;
    check_async("por_async_safe");
    step(2);
    por_vcc_dig = 1'b0; step(7);
    // conflicting pulls in OFF; error stays sticky
    cfg_tx_en = 1'b0; cfg_rx_en = 1'b0;
    step(6);
    cfg_wkpu = 1'b1; cfg_wkpd = 1'b1; step(3);
    cfg_wkpd = 1'b0; step(3);
    // drive strength 0 with TX, and TX reappearing during TURN
    cfg_wkpu = 1'b0; cfg_tx_en = 1'b1; cfg_drv = 2'b00; step(5);
    cfg_tx_en = 1'b0; step(2); cfg_tx_en = 1'b1; step(8);

    // randomized traffic with occasional POR pulses
    por_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        cfg_tx_en  = ($urandom_range(2) == 0);
        cfg_rx_en  = ($urandom_range(1) == 0);
        cfg_rx_clk = 1'($urandom);
        cfg_drv    = 2'($urandom);
      end
      if ($urandom_range(15) == 0) begin
        cfg_wkpu = 1'($urandom);
        cfg_wkpd = 1'($urandom);
      end
      if (por_left > 0) begin
        por_left--;
        if (por_left == 0) begin por_vcc_io = 1'b0; por_vcc_dig = 1'b0; end
      end else if ($urandom_range(99) == 0) begin
        por_left = $urandom_range(3, 1);
        if ($urandom_range(1) == 0) por_vcc_io = 1'b1; else por_vcc_dig = 1'b1;
        check_async("por_async_rand");
      end
      step(1);
    end
    por_vcc_io = 1'b0; por_vcc_dig = 1'b0;
    step(4);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain leftover=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
